voice_alarm_ctrl: RTL and testbench

- Consumes the one-cycle gas-alarm pulse qiti_en_voice from the gas detect stage.
- Drives an external one-wire voice playback chip: start pulse, then 8-bit track address, LSB first.
- Monitors the chip's busy line and repeats the announcement REPEAT times.
- Reports activity, completion and a no-response error to the panel logic.

---
 rtl/voice_alarm_ctrl.sv | 171 +++++++++++++++++
 tb/tb_voice_alarm_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/voice_alarm_ctrl.sv
// Gas-alarm voice announcer: drives a one-wire playback chip (start pulse + 8-bit track, LSB first)
// and repeats the track REPEAT times. Optional macro VOICE_PENDING_EN queues one retrigger.
module voice_alarm_ctrl #(
  parameter int unsigned T_UNIT       = 10000,
  parameter int unsigned START_CYC    = 250000,
  parameter logic [7:0]  TRACK_ADDR   = 8'h01,
  parameter int unsigned REPEAT       = 3,
  parameter int unsigned BUSY_TIMEOUT = 2500000,
  parameter int unsigned GAP_CYC      = 5000000
) (
  input  logic clk_50M,
  input  logic s_rst_n,
  input  logic qiti_en_voice,
  input  logic voice_busy,
  output logic voice_data,
  output logic voice_active,
  output logic play_done,
  output logic voice_err
);

`ifdef VOICE_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  localparam int unsigned MAX_A   = (START_CYC > 3 * T_UNIT) ? START_CYC : 3 * T_UNIT;
  localparam int unsigned MAX_B   = (BUSY_TIMEOUT > GAP_CYC) ? BUSY_TIMEOUT : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // The timer holds (duration - 1), so MAX_CYC-1 is the largest value it ever sees.
  localparam int TMR_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

  typedef enum logic [2:0] {
    IDLE, START, BIT_HI, BIT_LO, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic [TMR_W-1:0] tmr;
  logic             tmr_done;
  logic             busy_meta, busy_s;
  logic             err_nxt;
  logic             pending, pending_nxt;
  logic             play_fin;

  function automatic logic [TMR_W-1:0] load_val(input state_t s, input logic b);
    logic [TMR_W-1:0] v;
    v = '0;
    case (s)
      START:     v = TMR_W'(START_CYC - 1);
      BIT_HI:    v = b ? TMR_W'(3 * T_UNIT - 1) : TMR_W'(T_UNIT - 1);
      BIT_LO:    v = b ? TMR_W'(T_UNIT - 1) : TMR_W'(3 * T_UNIT - 1);
      WAIT_BUSY: v = TMR_W'(BUSY_TIMEOUT - 1);
      GAP:       v = TMR_W'(GAP_CYC - 1);
      default:   v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let both flops sample old values, forming a real 2-stage chain.
      busy_meta <= voice_busy;
      busy_s    <= busy_meta;
    end
  end

  assign tmr_done = (tmr == '0);

  // NOTE: only control state lives here, so every flop gets an async reset value.
  always_ff @(posedge clk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      rep_cnt   <= '0;
      tmr       <= '0;
      voice_err <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      rep_cnt   <= rep_cnt_nxt;
      voice_err <= err_nxt;
      pending   <= pending_nxt;
      if (state_nxt != state)
        tmr <= load_val(state_nxt, TRACK_ADDR[bit_idx_nxt]);
      else if (!tmr_done)
        tmr <= tmr - TMR_W'(1);
    end
  end

  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and a latch is never inferred.
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    rep_cnt_nxt = rep_cnt;
    err_nxt     = voice_err;
    pending_nxt = pending;
    play_fin    = 1'b0;
    play_done   = 1'b0;

    case (state)
      IDLE: begin
        if (qiti_en_voice) begin
          state_nxt   = START;
          bit_idx_nxt = '0;
          rep_cnt_nxt = '0;
          err_nxt     = 1'b0;
        end
      end
      START:  if (tmr_done) state_nxt = BIT_HI;
      BIT_HI: if (tmr_done) state_nxt = BIT_LO;
      BIT_LO: begin
        if (tmr_done) begin
          bit_idx_nxt = bit_idx + 3'd1;
          state_nxt   = (bit_idx == 3'd7) ? WAIT_BUSY : BIT_HI;
        end
      end
      WAIT_BUSY: begin
        if (busy_s) begin
          state_nxt = WAIT_DONE;
        end else if (tmr_done) begin
          err_nxt  = 1'b1;
          play_fin = 1'b1;
        end
      end
      WAIT_DONE: if (!busy_s) play_fin = 1'b1;
      GAP: begin
        if (tmr_done) begin
          state_nxt   = START;
          bit_idx_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (PEND_EN && state != IDLE && qiti_en_voice)
      pending_nxt = 1'b1;

    // A retrigger seen during the finishing cycle itself also restarts the sequence.
    if (play_fin) begin
      if (rep_cnt == REP_LAST) begin
        if (PEND_EN && (pending || qiti_en_voice)) begin
          state_nxt   = GAP;
          rep_cnt_nxt = '0;
          pending_nxt = 1'b0;
          err_nxt     = 1'b0;
        end else begin
          state_nxt = IDLE;
          play_done = 1'b1;
        end
      end else begin
        rep_cnt_nxt = rep_cnt + REP_W'(1);
        state_nxt   = GAP;
      end
    end
  end

  // Outputs decode straight from state so an async reset forces the line high at once.
  always_comb begin
    voice_data   = !(state == START || state == BIT_LO);
    voice_active = (state != IDLE);
  end

endmodule

// File: tb/tb_voice_alarm_ctrl.sv
// Randomized bench for voice_alarm_ctrl: a segment-level reference model builds the expected
// per-cycle waveform of {voice_data, voice_active, play_done, voice_err} ahead of the run.
module tb_voice_alarm_ctrl;

  localparam int unsigned T_UNIT       = 4;
  localparam int unsigned START_CYC    = 20;
  localparam logic [7:0]  TRACK_ADDR   = 8'hA5;
  localparam int unsigned REPEAT       = 2;
  localparam int unsigned BUSY_TIMEOUT = 50;
  localparam int unsigned GAP_CYC      = 10;
  localparam int MAXC = 16000;

`ifdef VOICE_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk_50M = 1'b0;
  logic s_rst_n;
  logic qiti_en_voice;
  logic voice_busy;
  logic voice_data;
  logic voice_active;
  logic play_done;
  logic voice_err;
  logic [3:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  bit       trig_a [MAXC];
  bit       busy_a [MAXC];
  bit [3:0] exp_a  [MAXC];
  int       bt;
  bit       m_err;
  bit       m_pend;
  int       m_rep;

  voice_alarm_ctrl #(
    .T_UNIT      (T_UNIT),
    .START_CYC   (START_CYC),
    .TRACK_ADDR  (TRACK_ADDR),
    .REPEAT      (REPEAT),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .GAP_CYC     (GAP_CYC)
  ) dut (
    .clk_50M      (clk_50M),
    .s_rst_n      (s_rst_n),
    .qiti_en_voice(qiti_en_voice),
    .voice_busy   (voice_busy),
    .voice_data   (voice_data),
    .voice_active (voice_active),
    .play_done    (play_done),
    .voice_err    (voice_err)
  );

  always #10 clk_50M = ~clk_50M;

  assign obs = {voice_data, voice_active, play_done, voice_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h ({data,active,done,err})", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  // Append n cycles with a fixed line level and activity, carrying the current error flag.
  task automatic put(input int n, input bit d, input bit a);
    for (int i = 0; i < n; i++) begin
      if (bt < MAXC) begin
        exp_a[bt] = {d, a, 1'b0, m_err};
        bt++;
      end
    end
  endtask

  task automatic build();
    int  sess, pl, fs, w, f, d, h, idle;
    bit  to, seq_end, bitv;
    bt = 0; m_err = 1'b0; sess = 0;
    for (int i = 0; i < MAXC; i++) begin
      trig_a[i] = 1'b0;
      busy_a[i] = 1'b0;
      exp_a[i]  = 4'b1000;
    end
    while (bt < MAXC - 3000) begin
      idle = $urandom_range(1, 12);
      put(idle, 1'b1, 1'b0);
      trig_a[bt-1] = 1'b1;
      m_err = 1'b0; m_pend = 1'b0; m_rep = 0; pl = 0; seq_end = 1'b0;
      while (!seq_end) begin
        fs = bt;
        put(START_CYC, 1'b0, 1'b1);
        for (int b = 0; b < 8; b++) begin
          bitv = TRACK_ADDR[b];
          put(bitv ? 3 * T_UNIT : T_UNIT, 1'b1, 1'b1);
          put(bitv ? T_UNIT : 3 * T_UNIT, 1'b0, 1'b1);
        end
        if ((sess == 0 && pl == 0) || (sess > 0 && bt < MAXC - 1500 && $urandom_range(0, 2) == 0)) begin
          trig_a[fs + $urandom_range(0, START_CYC + 32 * T_UNIT - 1)] = 1'b1;
          if (PEND) m_pend = 1'b1;
        end
        w  = bt;
        to = (sess == 0) || ($urandom_range(0, 3) == 0);
        if (to) begin
          f = w + BUSY_TIMEOUT - 1;
        end else begin
          d = (sess == 1) ? 0 : $urandom_range(0, 40);
          h = $urandom_range(1, 40);
          // Synchronizer: input high at cycle c shows as busy_s at c+2.
          for (int k = 0; k < h; k++) busy_a[w + d - 2 + k] = 1'b1;
          f = w + d + h;
        end
        put(f - w + 1, 1'b1, 1'b1);
        if (sess > 1 && $urandom_range(0, 4) == 0) trig_a[f] = 1'b1;
        if (to) m_err = 1'b1;
        if (m_rep == REPEAT - 1) begin
          if (PEND && (m_pend || trig_a[f])) begin
            m_err = 1'b0; m_pend = 1'b0; m_rep = 0;
            put(GAP_CYC, 1'b1, 1'b1);
          end else begin
            exp_a[f][1] = 1'b1;
            seq_end = 1'b1;
          end
        end else begin
          if (PEND && trig_a[f]) m_pend = 1'b1;
          m_rep++;
          put(GAP_CYC, 1'b1, 1'b1);
        end
        pl++;
      end
      sess++;
    end
    put(5, 1'b1, 1'b0);
  endtask

  initial begin
    #(20 * 40000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst_n = 1'b0;
    qiti_en_voice = 1'b0;
    voice_busy = 1'b0;
    repeat (3) tick();
    check("reset_state", {28'd0, obs}, 32'h8);
    @(negedge clk_50M) s_rst_n = 1'b1;

    // Reset while the start pulse holds the line low.
    tick(); qiti_en_voice = 1'b1;
    tick(); qiti_en_voice = 1'b0;
    repeat (5) tick();
    @(negedge clk_50M);
    check("in_start", {28'd0, obs}, 32'h4);
    #2 s_rst_n = 1'b0;
    #1 check("rst_mid_start", {28'd0, obs}, 32'h8);
    @(negedge clk_50M) s_rst_n = 1'b1;

    // Reset during the first BIT_HI (bit 0 = 1 lasts 12 cycles after the 20-cycle start).
    tick(); qiti_en_voice = 1'b1;
    tick(); qiti_en_voice = 1'b0;
    repeat (24) tick();
    @(negedge clk_50M);
    check("in_bit_hi", {28'd0, obs}, 32'hC);
    #2 s_rst_n = 1'b0;
    #1 check("rst_mid_bit_hi", {28'd0, obs}, 32'h8);
    @(negedge clk_50M) s_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk_50M);
      check("idle_after_rst", {28'd0, obs}, 32'h8);
    end

    build();
    tick();
    for (int c = 0; c < bt; c++) begin
      qiti_en_voice = trig_a[c];
      voice_busy    = busy_a[c];
      @(negedge clk_50M);
      check($sformatf("cyc%0d", c), {28'd0, obs}, {28'd0, exp_a[c]});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
